// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: pushbutton-driven run/set controller for a min:sec counter.
//   Purpose: debounces two active-low keys and sequences RUN -> SET_MIN ->
//   SET_SEC -> RUN on KEY[0] presses. In RUN it generates the 1 s count tick
//   from a prescaler and clears the counter on a KEY[1] press. In the set
//   modes a KEY[1] press increments the selected digit pair and BLINK flashes.
//   Optional feature macro: CLOCK_SET_AUTOREPEAT_EN (KEY[1] auto-repeat in the
//   set modes). The default build has no repeat logic.
//   Ports:
//     CLK      in   system clock, rising edge
//     RST      in   asynchronous reset, active low
//     KEY[1:0] in   raw pushbuttons, pressed = 0 (KEY[0] mode, KEY[1] adjust)
//     SW[9:0]  in   SW[0] = 1 enables run counting, SW[9:1] unused
//     TICK     out  one-cycle count enable
//     INC_SEC  out  one-cycle seconds increment
//     INC_MIN  out  one-cycle minutes increment
//     CLR      out  one-cycle counter clear
//     MODE     out  00 RUN, 01 SET_MIN, 10 SET_SEC
//     BLINK    out  blink phase for the digits being set
//
// state   | meaning
// RUN     | prescaler free-runs while SW[0]=1, KEY[1] clears the counter
// SET_MIN | KEY[1] increments minutes, BLINK active, prescaler held at 0
// SET_SEC | KEY[1] increments seconds, BLINK active, prescaler held at 0
module clock_set_ctrl #(
  parameter int TICK_DIV      = 50000000,
  parameter int DEB_CYCLES    = 1000000,
  parameter int REPEAT_CYCLES = 25000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] KEY,
  input  logic [9:0] SW,
  output logic       TICK,
  output logic       INC_SEC,
  output logic       INC_MIN,
  output logic       CLR,
  output logic [1:0] MODE,
  output logic       BLINK
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = $clog2(TICK_DIV / 2 + 1);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] HALF_MAX  = BW'(TICK_DIV / 2 - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {RUN = 2'b00, SET_MIN = 2'b01, SET_SEC = 2'b10} mode_e;

  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    deb_q, deb_d;
  logic [DW-1:0] deb_cnt_q [2];
  logic [DW-1:0] deb_cnt_d [2];
  logic [1:0]    press;

  mode_e         mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  logic          tick_q, tick_d, inc_sec_q, inc_sec_d, inc_min_q, inc_min_d, clr_q, clr_d;
  logic          rpt_fire;

  logic unused_sw;
  assign unused_sw = ^SW[9:1];

  // Debounce: the counter tracks consecutive cycles of disagreement between
  // the synchronized key and the accepted level; any agreeing cycle restarts it.
  always_comb begin
    deb_d = deb_q;
    press = '0;
    for (int k = 0; k < 2; k++) begin
      deb_cnt_d[k] = '0;
      if (sync2_q[k] != deb_q[k]) begin
        if (deb_cnt_q[k] == DEB_MAX) begin
          deb_d[k] = sync2_q[k];
          press[k] = ~sync2_q[k];
        end else begin
          deb_cnt_d[k] = deb_cnt_q[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      deb_q   <= 2'b11;
      for (int k = 0; k < 2; k++) deb_cnt_q[k] <= '0;
    end else begin
      sync1_q <= KEY;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      for (int k = 0; k < 2; k++) deb_cnt_q[k] <= deb_cnt_d[k];
    end
  end

`ifdef CLOCK_SET_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] RPT_MAX = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rpt_cnt_q;
  logic          rpt_act_q;
  logic          rpt_held;

  // Repeat stays armed only while KEY[1] remains accepted-low after a press
  // taken in a set mode; a release or a mode change disarms it.
  assign rpt_held = rpt_act_q & ~deb_d[1] & ~press[0];
  assign rpt_fire = rpt_held && (rpt_cnt_q == RPT_MAX);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rpt_cnt_q <= '0;
      rpt_act_q <= 1'b0;
    end else if (press[1] && !press[0] && mode_q != RUN) begin
      rpt_cnt_q <= '0;
      rpt_act_q <= 1'b1;
    end else if (rpt_held) begin
      rpt_cnt_q <= rpt_fire ? '0 : rpt_cnt_q + 1'b1;
    end else begin
      rpt_cnt_q <= '0;
      rpt_act_q <= 1'b0;
    end
  end
`else
  logic [31:0] unused_rpt_cycles;
  assign unused_rpt_cycles = REPEAT_CYCLES;
  assign rpt_fire = 1'b0;
`endif

  // A mode press takes priority; a KEY[1] press in the same cycle is dropped.
  always_comb begin
    mode_d      = mode_q;
    presc_d     = presc_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    tick_d      = 1'b0;
    inc_sec_d   = 1'b0;
    inc_min_d   = 1'b0;
    clr_d       = 1'b0;
    if (press[0]) begin
      presc_d     = '0;
      blink_d     = 1'b1;
      blink_cnt_d = HALF_MAX;
      unique case (mode_q)
        RUN:     mode_d = SET_MIN;
        SET_MIN: mode_d = SET_SEC;
        default: begin
          mode_d  = RUN;
          blink_d = 1'b0;
        end
      endcase
    end else begin
      unique case (mode_q)
        RUN: begin
          blink_d     = 1'b0;
          blink_cnt_d = '0;
          if (press[1]) begin
            clr_d   = 1'b1;
            presc_d = '0;
          end else if (SW[0]) begin
            if (presc_q == PRESC_MAX) begin
              presc_d = '0;
              tick_d  = 1'b1;
            end else begin
              presc_d = presc_q + 1'b1;
            end
          end
        end
        default: begin
          presc_d = '0;
          if (blink_cnt_q == '0) begin
            blink_cnt_d = HALF_MAX;
            blink_d     = ~blink_q;
          end else begin
            blink_cnt_d = blink_cnt_q - 1'b1;
          end
          if (press[1] || rpt_fire) begin
            inc_min_d = (mode_q == SET_MIN);
            inc_sec_d = (mode_q == SET_SEC);
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mode_q      <= RUN;
      presc_q     <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      tick_q      <= 1'b0;
      inc_sec_q   <= 1'b0;
      inc_min_q   <= 1'b0;
      clr_q       <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      tick_q      <= tick_d;
      inc_sec_q   <= inc_sec_d;
      inc_min_q   <= inc_min_d;
      clr_q       <= clr_d;
    end
  end

  assign TICK    = tick_q;
  assign INC_SEC = inc_sec_q;
  assign INC_MIN = inc_min_q;
  assign CLR     = clr_q;
  assign MODE    = mode_q;
  assign BLINK   = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Testbench for clock_set_ctrl with TICK_DIV=10, DEB_CYCLES=4, REPEAT_CYCLES=8.
// A behavioural model tracks mode, prescaler count and time-in-set-mode and
// predicts every output each cycle; scenario tasks add directed checks.
// Define CLOCK_SET_AUTOREPEAT_EN for both DUT and bench to test the repeat build.
module tb_clock_set_ctrl;
  localparam int TICK_DIV = 10, DEB_CYCLES = 4, REPEAT_CYCLES = 8;

  logic       CLK = 1'b0, RST = 1'b1;
  logic [1:0] KEY = 2'b11;
  logic [9:0] SW  = 10'd1;
  logic       TICK, INC_SEC, INC_MIN, CLR, BLINK;
  logic [1:0] MODE;
  logic [6:0] act;
  int n_tests = 0, n_fail = 0;

  clock_set_ctrl #(.TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) dut (
    .CLK(CLK), .RST(RST), .KEY(KEY), .SW(SW), .TICK(TICK), .INC_SEC(INC_SEC),
    .INC_MIN(INC_MIN), .CLR(CLR), .MODE(MODE), .BLINK(BLINK));

  always #5 CLK = ~CLK;
  assign act = {TICK, INC_SEC, INC_MIN, CLR, MODE, BLINK};

  // ---------------- reference model ----------------
  bit m_s1[2], m_s2[2], m_deb[2];
  int m_run[2];
  int m_mode, m_presc, m_age;
  bit e_tick, e_inc_sec, e_inc_min, e_clr;
`ifdef CLOCK_SET_AUTOREPEAT_EN
  bit m_rpt_on;
  int m_hold;
`endif

  function automatic void model_reset();
    m_mode = 0; m_presc = 0; m_age = 0;
    e_tick = 0; e_inc_sec = 0; e_inc_min = 0; e_clr = 0;
    for (int k = 0; k < 2; k++) begin
      m_s1[k] = 1; m_s2[k] = 1; m_deb[k] = 1; m_run[k] = 0;
    end
`ifdef CLOCK_SET_AUTOREPEAT_EN
    m_rpt_on = 0; m_hold = 0;
`endif
  endfunction

  function automatic void model_edge();
    bit pr[2];
    bit fire;
    if (!RST) begin model_reset(); return; end
    e_tick = 0; e_inc_sec = 0; e_inc_min = 0; e_clr = 0;
    for (int k = 0; k < 2; k++) begin
      pr[k] = 0;
      if (m_s2[k] != m_deb[k]) begin
        m_run[k]++;
        if (m_run[k] == DEB_CYCLES) begin
          m_deb[k] = m_s2[k]; m_run[k] = 0; pr[k] = !m_deb[k];
        end
      end else m_run[k] = 0;
      m_s2[k] = m_s1[k];
      m_s1[k] = KEY[k];
    end
    if (pr[0]) begin
      m_mode = (m_mode + 1) % 3; m_presc = 0; m_age = 0;
`ifdef CLOCK_SET_AUTOREPEAT_EN
      m_rpt_on = 0;
`endif
    end else if (m_mode == 0) begin
      if (pr[1]) begin e_clr = 1; m_presc = 0; end
      else if (SW[0]) begin
        m_presc++;
        if (m_presc == TICK_DIV) begin m_presc = 0; e_tick = 1; end
      end
    end else begin
      m_age++;
      fire = pr[1];
`ifdef CLOCK_SET_AUTOREPEAT_EN
      if (pr[1]) begin m_rpt_on = 1; m_hold = 0; end
      else if (m_rpt_on && !m_deb[1]) begin
        m_hold++;
        if (m_hold % REPEAT_CYCLES == 0) fire = 1;
      end else m_rpt_on = 0;
`endif
      e_inc_min = fire && m_mode == 1;
      e_inc_sec = fire && m_mode == 2;
    end
  endfunction

  function automatic logic [6:0] exp_vec();
    logic [1:0] md;
    logic bl;
    md = 2'(m_mode);
    bl = (m_mode != 0) && ((m_age / (TICK_DIV / 2)) % 2 == 0);
    return {e_tick, e_inc_sec, e_inc_min, e_clr, md, bl};
  endfunction

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic drive_steps(input logic [1:0] k, input int n);
    KEY = k;
    repeat (n) step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2 RST = 1'b0;
    model_reset();
    SW = 10'd1;
    repeat (3) begin
      step();
      n_tests++;
      if (act !== 7'd0) begin n_fail++; $display("FAIL reset_outputs got %b want 0000000", act); end
    end
    RST = 1'b1;
    for (int i = 1; i <= 35; i++) begin
      step();
      n_tests++;
      if (TICK !== (i % 10 == 0)) begin n_fail++; $display("FAIL tick_after_reset cycle %0d got %b want %b", i, TICK, (i % 10 == 0)); end
      n_tests++;
      if (act !== exp_vec()) begin n_fail++; $display("FAIL reset_model t=%0t got %b want %b", $time, act, exp_vec()); end
    end
  endtask

  task automatic test_key_debounce();
    int changes;
    logic [1:0] prev;
    drive_steps(2'b10, 2);
    KEY = 2'b11;
    repeat (10) begin
      step();
      n_tests++;
      if (MODE !== 2'b00) begin n_fail++; $display("FAIL glitch_mode got %b want 00", MODE); end
    end
    changes = 0;
    prev = MODE;
    for (int i = 0; i < 24; i++) begin
      KEY = (i < 12) ? 2'b10 : 2'b11;
      step();
      if (MODE !== prev) changes++;
      prev = MODE;
      n_tests++;
      if (act !== exp_vec()) begin n_fail++; $display("FAIL debounce_model t=%0t got %b want %b", $time, act, exp_vec()); end
    end
    n_tests++;
    if (changes != 1 || MODE !== 2'b01) begin n_fail++; $display("FAIL mode_press changes %0d mode %b want 1 change to 01", changes, MODE); end
  endtask

  task automatic test_set_min_inc();
    int n_min, n_other, last_edge, bad_period;
    logic prev_bl;
    n_min = 0; n_other = 0; last_edge = -1; bad_period = 0;
    prev_bl = BLINK;
    for (int i = 0; i < 24; i++) begin
      KEY = (i < 8) ? 2'b01 : 2'b11;
      step();
      n_min += int'(INC_MIN);
      n_other += int'(INC_SEC) + int'(TICK) + int'(CLR);
      if (BLINK !== prev_bl) begin
        if (last_edge >= 0 && i - last_edge != TICK_DIV / 2) bad_period++;
        last_edge = i;
      end
      prev_bl = BLINK;
      n_tests++;
      if (act !== exp_vec()) begin n_fail++; $display("FAIL setmin_model t=%0t got %b want %b", $time, act, exp_vec()); end
    end
    n_tests++;
    if (n_min != 1 || n_other != 0) begin n_fail++; $display("FAIL setmin_inc inc_min %0d others %0d want 1 and 0", n_min, n_other); end
    n_tests++;
    if (bad_period != 0 || last_edge < 0) begin n_fail++; $display("FAIL blink_period bad %0d last %0d want half-period 5", bad_period, last_edge); end
  endtask

  task automatic test_run_hold_clr();
    int entry, gap, n_tick, n_clr, clr_at, tick_at;
    logic [1:0] prev;
    drive_steps(2'b10, 8);
    drive_steps(2'b11, 8);
    entry = -1; gap = -1; prev = MODE;
    for (int j = 0; j < 30 && gap < 0; j++) begin
      KEY = (j < 8) ? 2'b10 : 2'b11;
      step();
      if (MODE === 2'b00 && prev !== 2'b00) entry = j;
      if (entry >= 0 && TICK === 1'b1) gap = j - entry;
      prev = MODE;
      n_tests++;
      if (act !== exp_vec()) begin n_fail++; $display("FAIL run_entry_model t=%0t got %b want %b", $time, act, exp_vec()); end
    end
    n_tests++;
    if (gap != 10) begin n_fail++; $display("FAIL first_tick_after_entry got %0d want 10", gap); end
    repeat (3) step();
    SW = 10'd0; n_tick = 0;
    repeat (25) begin step(); n_tick += int'(TICK); end
    n_tests++;
    if (n_tick != 0) begin n_fail++; $display("FAIL hold_no_tick got %0d ticks want 0", n_tick); end
    SW = 10'd1; gap = -1;
    for (int j = 1; j <= 15 && gap < 0; j++) begin
      step();
      if (TICK === 1'b1) gap = j;
      n_tests++;
      if (act !== exp_vec()) begin n_fail++; $display("FAIL resume_model t=%0t got %b want %b", $time, act, exp_vec()); end
    end
    n_tests++;
    if (gap != 7) begin n_fail++; $display("FAIL resume_tick got %0d want 7", gap); end
    n_clr = 0; clr_at = -1; tick_at = -1;
    for (int j = 0; j < 30; j++) begin
      KEY = (j < 8) ? 2'b01 : 2'b11;
      step();
      if (CLR === 1'b1) begin n_clr++; clr_at = j; end
      if (clr_at >= 0 && tick_at < 0 && TICK === 1'b1) tick_at = j;
      n_tests++;
      if (act !== exp_vec()) begin n_fail++; $display("FAIL clr_model t=%0t got %b want %b", $time, act, exp_vec()); end
    end
    n_tests++;
    if (n_clr != 1 || tick_at - clr_at != 10) begin n_fail++; $display("FAIL clr_then_tick clr %0d gap %0d want 1 and 10", n_clr, tick_at - clr_at); end
  endtask

  task automatic test_simultaneous();
    int n_inc, n_clr;
    drive_steps(2'b10, 8);
    drive_steps(2'b11, 8);
    n_inc = 0;
    for (int i = 0; i < 16; i++) begin
      KEY = (i < 8) ? 2'b00 : 2'b11;
      step();
      n_inc += int'(INC_MIN) + int'(INC_SEC);
      n_tests++;
      if (act !== exp_vec()) begin n_fail++; $display("FAIL simul_model t=%0t got %b want %b", $time, act, exp_vec()); end
    end
    n_tests++;
    if (MODE !== 2'b10 || n_inc != 0) begin n_fail++; $display("FAIL simul_press mode %b inc %0d want 10 and 0", MODE, n_inc); end
    drive_steps(2'b01, 3);
    RST = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (act !== 7'd0) begin n_fail++; $display("FAIL async_reset got %b want 0000000", act); end
    repeat (2) step();
    RST = 1'b1;
    n_clr = 0;
    for (int i = 0; i < 22; i++) begin
      KEY = (i < 12) ? 2'b01 : 2'b11;
      step();
      n_clr += int'(CLR);
      n_tests++;
      if (act !== exp_vec()) begin n_fail++; $display("FAIL post_reset_model t=%0t got %b want %b", $time, act, exp_vec()); end
    end
    n_tests++;
    if (n_clr != 1) begin n_fail++; $display("FAIL held_through_reset clr %0d want 1", n_clr); end
  endtask

  task automatic test_autorepeat();
    int offs[$];
    int expo[$];
    int found, ok;
`ifdef CLOCK_SET_AUTOREPEAT_EN
    expo = '{0, 8, 16, 24};
`else
    expo = '{0};
`endif
    repeat (2) begin drive_steps(2'b10, 8); drive_steps(2'b11, 8); end
    n_tests++;
    if (MODE !== 2'b10) begin n_fail++; $display("FAIL enter_set_sec got %b want 10", MODE); end
    KEY = 2'b01; found = 0;
    for (int j = 0; j < 20 && found == 0; j++) begin
      step();
      if (INC_SEC === 1'b1) found = 1;
    end
    n_tests++;
    if (found == 0) begin n_fail++; $display("FAIL repeat_press_timeout got no INC_SEC want one within 20 cycles"); end
    offs.push_back(0);
    for (int j = 1; j <= 44; j++) begin
      if (j == 25) KEY = 2'b11;
      step();
      if (INC_SEC === 1'b1) offs.push_back(j);
      n_tests++;
      if (act !== exp_vec()) begin n_fail++; $display("FAIL repeat_model t=%0t got %b want %b", $time, act, exp_vec()); end
    end
    ok = (offs.size() == expo.size());
    if (ok) foreach (offs[i]) if (offs[i] != expo[i]) ok = 0;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL repeat_offsets got %p want %p", offs, expo); end
  endtask

  task automatic test_random();
    int hold[2];
    int sw_hold, rst_hold;
    hold[0] = 1; hold[1] = 1; sw_hold = 1; rst_hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) RST = 1'b1;
      end else if ($urandom_range(299) == 0) begin
        RST = 1'b0; model_reset(); rst_hold = int'($urandom_range(3, 1));
      end
      for (int k = 0; k < 2; k++) begin
        hold[k]--;
        if (hold[k] == 0) begin KEY[k] = ~KEY[k]; hold[k] = int'($urandom_range(12, 1)); end
      end
      sw_hold--;
      if (sw_hold == 0) begin SW = 10'($urandom); sw_hold = int'($urandom_range(30, 1)); end
      step();
      n_tests++;
      if (act !== exp_vec()) begin n_fail++; $display("FAIL random_model t=%0t got %b want %b", $time, act, exp_vec()); end
      n_tests++;
      if ($countones({TICK, INC_SEC, INC_MIN, CLR}) > 1) begin n_fail++; $display("FAIL pulse_exclusive got %b want at most one high", {TICK, INC_SEC, INC_MIN, CLR}); end
    end
    KEY = 2'b11; RST = 1'b1;
  endtask

  initial begin
    test_reset();
    test_key_debounce();
    test_set_min_inc();
    test_run_hold_clr();
    test_simultaneous();
    test_autorepeat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 The block SHALL have the parameter TICK_DIV, default 50000000: CLK cycles per 1 s count tick (>=4, even).
REQ-002 The block SHALL have the parameter DEB_CYCLES, default 1000000: consecutive stable cycles needed to accept a key level change.
REQ-003 The block SHALL have the parameter REPEAT_CYCLES, default 25000000: auto-repeat interval in cycles (used only under REQ-026).
REQ-004 CLK  in  1  SHALL be the single clock; all state is rising-edge.
REQ-005 RST  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 KEY  in  2  SHALL be the raw pushbuttons, active-low (pressed=0): KEY[0] mode, KEY[1] adjust.
REQ-007 SW  in  10  SHALL be the slide switches: SW[0]=1 enables run counting; SW[9:1] ignored.
REQ-008 TICK  out  1  SHALL be the one-cycle count-enable pulse to the seconds/minutes counter.
REQ-009 INC_SEC / INC_MIN  out  1 each  SHALL be one-cycle increment pulses to the seconds/minutes digits.
REQ-010 CLR  out  1  SHALL be the one-cycle clear pulse to the counter.
REQ-011 MODE  out  2  SHALL indicate the mode: 00 RUN, 01 SET_MIN, 10 SET_SEC; 11 is never output.
REQ-012 BLINK  out  1  SHALL be the display-blink phase for the digits being set.

Function
REQ-013 Each KEY bit SHALL pass through a 2-flop synchronizer; its debounced level SHALL change only after the synchronized value differs from it for DEB_CYCLES consecutive cycles, and any mismatch-free cycle SHALL reset the count.
REQ-014 A press event SHALL be a debounced 1->0 transition; release SHALL generate no event; all action outputs SHALL be registered and asserted the cycle after the event.
REQ-015 The FSM SHALL follow RUN -> SET_MIN -> SET_SEC -> RUN, advancing on each KEY[0] press event.
REQ-016 In RUN, the prescaler SHALL count 0..TICK_DIV-1 while SW[0]=1 and pulse TICK for one cycle on wrap; while SW[0]=0 it SHALL hold its value and TICK SHALL stay 0.
REQ-017 In RUN, a KEY[1] press SHALL pulse CLR once and zero the prescaler, with no TICK in that cycle.
REQ-018 In SET_MIN / SET_SEC, a KEY[1] press SHALL pulse INC_MIN / INC_SEC once; TICK SHALL be 0 and the prescaler held at 0.
REQ-019 On entry to RUN, the prescaler SHALL start from 0, so the first TICK occurs TICK_DIV cycles after entry when SW[0]=1.
REQ-020 BLINK SHALL toggle every TICK_DIV/2 cycles in the SET modes, starting at 1 on mode entry, and SHALL be 0 in RUN.
REQ-021 When KEY[0] and KEY[1] press events occur in the same cycle, the mode change SHALL win and the KEY[1] event SHALL be discarded.
REQ-022 At most one of TICK, INC_SEC, INC_MIN, CLR SHALL be high in any cycle.

Reset
REQ-023 While RST=0, MODE SHALL be 00 and TICK, INC_SEC, INC_MIN, CLR, BLINK 0; the prescaler, debounce counters and repeat counter SHALL be 0; the debounced levels SHALL be 1 (released).
REQ-024 Reset asserted mid-operation (any mode, mid-debounce, mid-repeat) SHALL immediately force the REQ-023 state; a key held low through reset release SHALL register as a new press after DEB_CYCLES.
REQ-025 The first prescaler increment SHALL occur on the first CLK edge after RST goes high.

Configuration
REQ-026 With CLOCK_SET_AUTOREPEAT_EN defined, holding KEY[1] (debounced low) in SET_MIN/SET_SEC SHALL emit an extra INC_MIN/INC_SEC pulse every REPEAT_CYCLES after the initial press pulse until release or mode change; CLR in RUN SHALL never repeat.
REQ-027 Without CLOCK_SET_AUTOREPEAT_EN, exactly one increment pulse SHALL be emitted per press, no repeat counter SHALL be instantiated, and REPEAT_CYCLES SHALL be unused.

Verification (TICK_DIV=10, DEB_CYCLES=4, REPEAT_CYCLES=8)
REQ-028 The bench SHALL cover: RST low 3 cycles, then high with SW[0]=1 -> all outputs 0 during reset; TICK on the 10th cycle after release, then every 10 cycles.
REQ-029 The bench SHALL cover: KEY[0] low 2 cycles, then high -> MODE stays 00; KEY[0] low 12 cycles -> MODE 01 exactly once, no change on release.
REQ-030 The bench SHALL cover: in SET_MIN, a KEY[1] press -> exactly one INC_MIN; TICK 0 throughout; BLINK period 10 cycles.
REQ-031 The bench SHALL cover: in RUN, SW[0]=0 for 25 cycles mid-count -> no TICK; after SW[0]=1, TICK spacing resumes from the held prescaler value; a KEY[1] press -> one CLR pulse, next TICK 10 cycles later.
REQ-032 The bench SHALL cover: in SET_MIN, simultaneous KEY[0]/KEY[1] presses -> MODE 10 and no INC_MIN; RST pulsed low mid-SET_SEC -> MODE 00 with all pulses 0.
REQ-033 The bench SHALL cover: in SET_SEC, KEY[1] held 30 cycles past debounce -> with the macro, INC_SEC at the press then at +8, +16, +24; without the macro, a single INC_SEC.
